ff_access_ctrl: RTL and testbench
=================================

FF_ACCESS_CTRL -- requirements
Module: ff_access_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, FIFO address width; depth = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 8, FIFO word width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream word available.
REQ-006 in_data  input  DATA_WIDTH  upstream word.
REQ-007 in_ready  output  1  upstream word accepted this cycle when in_valid & in_ready.
REQ-008 out_valid  output  1  downstream word available.
REQ-009 out_data  output  DATA_WIDTH  downstream word.
REQ-010 out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-011 ff_en  output  1  FIFO operation request to the status block.
REQ-012 ff_push_pop  output  1  1 = push, 0 = pop; don't-care when ff_en = 0.
REQ-013 ff_wdata  output  DATA_WIDTH  push data, equals in_data.
REQ-014 ff_rdata  input  DATA_WIDTH  FIFO read data, valid one cycle after a pop issue.
REQ-015 full_signal, empty_signal  input  1 each  FIFO status.
REQ-016 ff_cs  input  1  status-block chip select (low = overflow/underflow).
REQ-017 proto_err  output  1  sticky: ff_en = 1 while ff_cs = 0 was observed.
REQ-018 ff_count  output  ADDR_WIDTH+1  FIFO occupancy (see Configuration).

Function
REQ-019 One FIFO operation per cycle at most; ff_en = push_grant | pop_grant, ff_push_pop = push_grant.
REQ-020 push_req = in_valid & ~full_signal; pop_req = ~empty_signal & (credits > 0).
REQ-021 credits = 2 - skid_cnt - inflight + (out_valid & out_ready); skid_cnt in 0..2, inflight in 0..1.
REQ-022 Arbiter FSM states PRI_PUSH, PRI_POP: single requester always granted; both requesting -> the prioritised one granted, then FSM moves to the other state; no request or single grant -> state unchanged.
REQ-023 in_ready = push_grant (combinational; in_ready = 0 whenever full_signal = 1).
REQ-024 Pop granted at cycle t sets inflight; at cycle t+1 ff_rdata is written into the skid buffer; out_valid no earlier than t+2.
REQ-025 Skid buffer is 2-entry FIFO order; out_data = head entry; out_valid = (skid_cnt != 0); write and drain in same cycle allowed, skid_cnt unchanged.
REQ-026 Sustained in_valid & out_ready with both FIFO ends active: alternating grants, no word lost, duplicated or reordered.
REQ-027 Push while full or pop while empty is never issued; proto_err sets if ff_en & ~ff_cs and holds until reset.

Reset
REQ-028 On rst: in_ready=0, out_valid=0, out_data=0, ff_en=0, proto_err=0, ff_count=0, skid_cnt=0, inflight=0, FSM=PRI_PUSH.
REQ-029 Reset mid-operation discards an in-flight pop's data and all skid contents; FIFO pointers are reset by their owner in the same cycle.
REQ-030 No grant is issued in any cycle with rst = 1.

Configuration
REQ-031 Macro FF_ACCESS_CNT_EN defined: ff_count +1 on push grant, -1 on pop grant, saturating at 0 and 2**ADDR_WIDTH.
REQ-032 Macro undefined: ff_count tied to 0, counter logic absent; all other behaviour identical.

Structure
REQ-033 Shared package cnn_fifo_pkg holds arbiter state enum (PRI_PUSH, PRI_POP) and constant SKID_DEPTH = 2.
REQ-034 Sub-module ff_skid_buf implements the 2-entry output buffer (wr, rd, data, count).

Verification
REQ-035 Reset, then in_valid=1, in_data=0x11..0x18, out_ready=0, empty->full over 8 pushes -> in_ready=0 on 9th cycle, ff_en pop grants stop once skid_cnt=2, proto_err=0.
REQ-036 FIFO holds 0xA5, out_ready=1, no input -> pop issued at t, out_valid=1 with out_data=0xA5 at t+2, one cycle.
REQ-037 Both requesting for 6 cycles from PRI_PUSH -> grants push,pop,push,pop,push,pop.
REQ-038 out_ready=0 after 2 words buffered, empty_signal=0 -> no further pop grants until out_ready=1.
REQ-039 rst asserted cycle after a pop grant -> out_valid stays 0, inflight data dropped, FSM=PRI_PUSH.
REQ-040 Force ff_cs=0 with ff_en=1 -> proto_err=1 next cycle and held; with FF_ACCESS_CNT_EN, 3 pushes 1 pop -> ff_count=2.

Source files
------------

// File: rtl/cnn_fifo_pkg.sv
// -----------------------------------------------------------------------------
// cnn_fifo_pkg
//   Shared definitions for the FIFO access controller:
//     - arb_state_e   : push/pop arbiter priority state
//     - SKID_DEPTH    : output skid buffer depth (2 entries)
//     - SKID_CNT_FULL : SKID_DEPTH sized to the skid occupancy counter
//     - skid_credits  : free skid slots available for a new pop issue
// -----------------------------------------------------------------------------
package cnn_fifo_pkg;

   typedef enum logic {
      PRI_PUSH = 1'b0,
      PRI_POP  = 1'b1
   } arb_state_e;

   localparam int unsigned SKID_DEPTH    = 2;
   localparam logic [1:0]  SKID_CNT_FULL = 2'(SKID_DEPTH);

   // Slots left once buffered words and the in-flight read are counted,
   // plus the slot freed by a drain in this same cycle. The result is
   // 0..3 while skid_cnt + inflight <= SKID_DEPTH; bit 2 only ever sets if
   // that bound were broken (wrap below zero).
   function automatic logic [2:0] skid_credits(input logic [1:0] skid_cnt,
                                               input logic       inflight,
                                               input logic       drain);
      return 3'(SKID_DEPTH) + {2'b00, drain} - {1'b0, skid_cnt} - {2'b00, inflight};
   endfunction

endpackage

// File: rtl/ff_skid_buf.sv
// -----------------------------------------------------------------------------
// ff_skid_buf
//   Two-entry FIFO-ordered skid buffer holding words read from the main FIFO
//   until the downstream side takes them. Write and read in the same cycle is
//   allowed and leaves the count unchanged.
//
//   Ports
//     clk      in   clock, rising edge
//     rst      in   synchronous active-high reset; clears contents and count
//     wr_i     in   write wdata_i (ignored when full and not reading)
//     wdata_i  in   DATA_WIDTH word to store
//     rd_i     in   drop the head entry (ignored when empty)
//     rdata_o  out  head entry
//     count_o  out  occupancy 0..2
// -----------------------------------------------------------------------------
module ff_skid_buf
   import cnn_fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic                  rd_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [1:0]            count_o
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic                  wp_q;
   logic                  rp_q;
   logic [1:0]            cnt_q;
   logic [1:0]            cnt_d;
   logic                  do_wr;
   logic                  do_rd;

   always_comb begin
      do_rd = rd_i & (cnt_q != 2'd0);
      // A write into a full buffer is only legal when the head leaves now.
      do_wr = wr_i & ((cnt_q != SKID_CNT_FULL) | do_rd);
      cnt_d = cnt_q;
      if (do_wr && !do_rd) begin
         cnt_d = cnt_q + 2'd1;
      end else if (do_rd && !do_wr) begin
         cnt_d = cnt_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         if (do_wr) begin
            mem_q[wp_q] <= wdata_i;
            wp_q        <= ~wp_q;
         end
         if (do_rd) begin
            rp_q <= ~rp_q;
         end
         cnt_q <= cnt_d;
      end
   end

   assign rdata_o = mem_q[rp_q];
   assign count_o = cnt_q;

endmodule

// File: rtl/ff_access_ctrl.sv
// -----------------------------------------------------------------------------
// ff_access_ctrl
//   Single-port access controller in front of a FIFO status block. Each cycle
//   it issues at most one FIFO operation (push of the upstream word or pop
//   toward the downstream side), arbitrating with an alternating-priority FSM
//   when both are wanted. Popped data returns one cycle after issue and lands
//   in a 2-entry skid buffer; pops are only issued while the buffer has a
//   guaranteed free slot, so no returned word is ever dropped.
//
//   Ports
//     clk           in   clock, rising edge
//     rst           in   synchronous active-high reset
//     in_valid      in   upstream word available
//     in_data       in   upstream word (DATA_WIDTH)
//     in_ready      out  upstream word accepted this cycle (= push grant)
//     out_valid     out  downstream word available
//     out_data      out  downstream word (DATA_WIDTH)
//     out_ready     in   downstream accepts
//     ff_en         out  FIFO operation request
//     ff_push_pop   out  1 = push, 0 = pop
//     ff_wdata      out  push data (= in_data)
//     ff_rdata      in   FIFO read data, one cycle after a pop issue
//     full_signal   in   FIFO full
//     empty_signal  in   FIFO empty
//     ff_cs         in   status-block chip select (low = overflow/underflow)
//     proto_err     out  sticky: an operation was issued while ff_cs was low
//     ff_count      out  FIFO occupancy (ADDR_WIDTH+1)
//
//   Build option
//     FF_ACCESS_CNT_EN  defined: ff_count tracks pushes/pops, saturating at
//                       0 and 2**ADDR_WIDTH. Undefined: ff_count is 0.
// -----------------------------------------------------------------------------
module ff_access_ctrl
   import cnn_fifo_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 3,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic                  ff_en,
   output logic                  ff_push_pop,
   output logic [DATA_WIDTH-1:0] ff_wdata,
   input  logic [DATA_WIDTH-1:0] ff_rdata,
   input  logic                  full_signal,
   input  logic                  empty_signal,
   input  logic                  ff_cs,
   output logic                  proto_err,
   output logic [ADDR_WIDTH:0]   ff_count
);

   arb_state_e state_q;
   arb_state_e state_d;
   logic       inflight_q;
   logic       proto_err_q;
   logic [1:0] skid_cnt;
   logic       drain;
   logic [2:0] credits;
   logic       push_req;
   logic       pop_req;
   logic       push_grant;
   logic       pop_grant;

   // ---------------------------------------------------------------------------
   // Requests
   // ---------------------------------------------------------------------------
   always_comb begin
      drain    = out_valid & out_ready;
      credits  = skid_credits(skid_cnt, inflight_q, drain);
      push_req = in_valid & ~full_signal;
      // credits[2] would only mean a wrapped (negative) credit count.
      pop_req  = ~empty_signal & (credits != 3'd0) & ~credits[2];
   end

   // ---------------------------------------------------------------------------
   // Arbiter: next state and grants
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      push_grant = 1'b0;
      pop_grant  = 1'b0;
      if (rst) begin
         state_d = PRI_PUSH;
      end else if (push_req && pop_req) begin
         if (state_q == PRI_PUSH) begin
            push_grant = 1'b1;
            state_d    = PRI_POP;
         end else begin
            pop_grant  = 1'b1;
            state_d    = PRI_PUSH;
         end
      end else begin
         push_grant = push_req;
         pop_grant  = pop_req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= PRI_PUSH;
         inflight_q  <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= pop_grant;
         if (ff_en && !ff_cs) begin
            proto_err_q <= 1'b1;
         end
      end
   end

   assign in_ready    = push_grant;
   assign ff_en       = push_grant | pop_grant;
   assign ff_push_pop = push_grant;
   assign ff_wdata    = in_data;
   assign proto_err   = proto_err_q;

   // ---------------------------------------------------------------------------
   // Output skid buffer: captures ff_rdata the cycle after a pop issue
   // ---------------------------------------------------------------------------
   ff_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (inflight_q),
      .wdata_i (ff_rdata),
      .rd_i    (out_ready),
      .rdata_o (out_data),
      .count_o (skid_cnt)
   );

   assign out_valid = (skid_cnt != 2'd0);

   // ---------------------------------------------------------------------------
   // Occupancy counter
   // ---------------------------------------------------------------------------
`ifdef FF_ACCESS_CNT_EN
   localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH:0] cnt_q;
   logic [ADDR_WIDTH:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (push_grant && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end else if (pop_grant && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ff_count = cnt_q;
`else
   assign ff_count = '0;
`endif

endmodule

// File: tb/tb_ff_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ff_access_ctrl
//   Directed bench for ff_access_ctrl. A behavioural 8-deep FIFO status block
//   answers push/pop requests; hold_empty lets the bench present an empty
//   FIFO to the DUT while words are being loaded. Accepted upstream words are
//   queued as expected downstream words and compared in order on delivery.
// -----------------------------------------------------------------------------
module tb_ff_access_ctrl;
   import cnn_fifo_pkg::*;

   localparam int unsigned AW = 3;
   localparam int unsigned DW = 8;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic          ff_en;
   logic          ff_push_pop;
   logic [DW-1:0] ff_wdata;
   logic [DW-1:0] ff_rdata;
   logic          full_signal;
   logic          empty_signal;
   logic          ff_cs;
   logic          proto_err;
   logic [AW:0]   ff_count;

   logic          hold_empty;
   logic [DW-1:0] fmem [8];
   logic [2:0]    wp;
   logic [2:0]    rp;
   logic [3:0]    fcnt;

   int unsigned   n_vec;
   int unsigned   n_err;
   logic [DW-1:0] sb [$];

   ff_access_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .ff_en        (ff_en),
      .ff_push_pop  (ff_push_pop),
      .ff_wdata     (ff_wdata),
      .ff_rdata     (ff_rdata),
      .full_signal  (full_signal),
      .empty_signal (empty_signal),
      .ff_cs        (ff_cs),
      .proto_err    (proto_err),
      .ff_count     (ff_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural FIFO status block
   always @(posedge clk) begin
      if (rst) begin
         wp       <= '0;
         rp       <= '0;
         fcnt     <= '0;
         ff_rdata <= '0;
      end else if (ff_en) begin
         if (ff_push_pop) begin
            fmem[wp] <= ff_wdata;
            wp       <= wp + 3'd1;
            fcnt     <= fcnt + 4'd1;
         end else begin
            ff_rdata <= fmem[rp];
            rp       <= rp + 3'd1;
            fcnt     <= fcnt - 4'd1;
         end
      end
   end

   assign full_signal  = (fcnt == 4'd8);
   assign empty_signal = (fcnt == 4'd0) | hold_empty;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before 500us");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs_v, input logic [31:0] exp_v);
      n_vec++;
      assert (obs_v === exp_v) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs_v, exp_v);
      end
   endtask

   // Sample at the falling edge; scoreboard and protocol checks every cycle.
   task automatic obs();
      @(negedge clk);
      if (rst) begin
         sb.delete();
      end else begin
         if (ff_en && ff_push_pop) begin
            chk("push_while_full", {31'd0, full_signal}, 32'd0);
            chk("ff_wdata", {24'd0, ff_wdata}, {24'd0, in_data});
         end
         if (ff_en && !ff_push_pop) begin
            chk("pop_while_empty", {31'd0, empty_signal}, 32'd0);
         end
         if (in_valid && in_ready) begin
            sb.push_back(in_data);
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("spurious_out", {31'd0, out_valid}, 32'd0);
            end else begin
               chk("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
            end
         end
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      in_valid   = 1'b1;
      in_data    = 8'h99;
      out_ready  = 1'b1;
      hold_empty = 1'b0;
      ff_cs      = 1'b1;
      repeat (2) begin
         obs();
         adv();
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
   endtask

   // Push one word while the DUT sees an empty FIFO (no pop competes).
   task automatic preload(input logic [DW-1:0] d);
      hold_empty = 1'b1;
      in_valid   = 1'b1;
      in_data    = d;
      obs();
      chk("preload_ready", {31'd0, in_ready}, 32'd1);
      adv();
      in_valid = 1'b0;
   endtask

   task automatic drain_all(input string tag);
      int unsigned k;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      hold_empty = 1'b0;
      k = 0;
      while ((k < 40) && ((sb.size() != 0) || out_valid || (fcnt != 0))) begin
         obs();
         adv();
         k++;
      end
      chk({tag, "_sb_left"}, sb.size(), 32'd0);
      chk({tag, "_out_valid_end"}, {31'd0, out_valid}, 32'd0);
   endtask

   int unsigned pops;
   int unsigned exp_cnt;

   initial begin
      n_vec = 0;
      n_err = 0;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      ff_cs = 1'b1; hold_empty = 1'b0;

      // ---- reset state, no grant during reset ----
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
      obs(); adv();
      obs();
      chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
      chk("rst_ff_en",     {31'd0, ff_en},     32'd0);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data",  {24'd0, out_data},  32'd0);
      chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
      chk("rst_ff_count",  {28'd0, ff_count},  32'd0);
      adv();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

      // ---- single word: pop at t, out_valid at t+2 for one cycle ----
      do_reset();
      preload(8'hA5);
      hold_empty = 1'b0; out_ready = 1'b1;
      obs();
      chk("t0_pop_issue", {30'd0, ff_en, ff_push_pop}, 32'd2);
      adv();
      obs();
      chk("t1_out_valid", {31'd0, out_valid}, 32'd0);
      adv();
      obs();
      chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
      chk("t2_out_data",  {24'd0, out_data},  32'hA5);
      adv();
      obs();
      chk("t3_out_valid", {31'd0, out_valid}, 32'd0);
      adv();

      // ---- fill to full, pops stop at two buffered words ----
      do_reset();
      hold_empty = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h11 + i);
         obs();
         if (i < 8) chk("fill_in_ready", {31'd0, in_ready}, 32'd1);
         else       chk("full_in_ready", {31'd0, in_ready}, 32'd0);
         adv();
      end
      in_valid = 1'b0; hold_empty = 1'b0;
      pops = 0;
      for (int i = 0; i < 6; i++) begin
         obs();
         if (ff_en && !ff_push_pop) pops++;
         adv();
      end
      chk("fill_pop_count", pops, 32'd2);
      obs();
      chk("fill_out_valid", {31'd0, out_valid}, 32'd1);
      chk("fill_out_head",  {24'd0, out_data},  32'h11);
      chk("fill_proto_err", {31'd0, proto_err}, 32'd0);
      adv();
      for (int i = 0; i < 4; i++) begin
         obs();
         chk("stall_no_pop", {31'd0, ff_en}, 32'd0);
         adv();
      end
      drain_all("fill");

      // ---- alternating grants from PRI_PUSH, then sustained traffic ----
      do_reset();
      preload(8'h30);
      hold_empty = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         in_data = 8'(8'h40 + i);
         obs();
         chk("alt_grant", {30'd0, ff_en, ff_push_pop}, (i % 2 == 0) ? 32'd3 : 32'd2);
         adv();
      end
      for (int i = 0; i < 24; i++) begin
         in_valid  = (i % 3 != 0);
         out_ready = (i % 4 != 1);
         in_data   = 8'(8'h60 + i);
         obs();
         adv();
      end
      drain_all("mix");

      // ---- reset the cycle after a pop grant ----
      do_reset();
      preload(8'h55);
      hold_empty = 1'b0; in_valid = 1'b1; in_data = 8'h56; out_ready = 1'b1;
      obs();
      chk("r39_push", {30'd0, ff_en, ff_push_pop}, 32'd3);
      adv();
      in_valid = 1'b0;
      obs();
      chk("r39_pop", {30'd0, ff_en, ff_push_pop}, 32'd2);
      chk("r39_state_pop", {31'd0, dut.state_q}, {31'd0, PRI_POP});
      adv();
      rst = 1'b1; in_valid = 1'b1; in_data = 8'h57;
      obs();
      chk("r39_no_grant_rst", {31'd0, ff_en}, 32'd0);
      adv();
      rst = 1'b0; in_valid = 1'b0;
      obs();
      chk("r39_state_push", {31'd0, dut.state_q}, {31'd0, PRI_PUSH});
      adv();
      for (int i = 0; i < 3; i++) begin
         obs();
         chk("r39_out_valid", {31'd0, out_valid}, 32'd0);
         adv();
      end

      // ---- protocol error and occupancy counter ----
      do_reset();
      hold_empty = 1'b1; in_valid = 1'b1; in_data = 8'h77; ff_cs = 1'b0;
      obs();
      chk("pe_ff_en", {31'd0, ff_en}, 32'd1);
      chk("pe_before", {31'd0, proto_err}, 32'd0);
      adv();
      ff_cs = 1'b1;
      for (int i = 0; i < 2; i++) begin
         in_data = 8'(8'h78 + i);
         obs();
         chk("pe_held", {31'd0, proto_err}, 32'd1);
         adv();
      end
      in_valid = 1'b0; hold_empty = 1'b0; out_ready = 1'b0;
      obs();
      chk("cnt_pop", {30'd0, ff_en, ff_push_pop}, 32'd2);
      adv();
      hold_empty = 1'b1;
`ifdef FF_ACCESS_CNT_EN
      exp_cnt = 2;
`else
      exp_cnt = 0;
`endif
      obs();
      chk("ff_count_3p1p", {28'd0, ff_count}, exp_cnt);
      chk("pe_still", {31'd0, proto_err}, 32'd1);
      adv();
      do_reset();
      obs();
      chk("pe_cleared", {31'd0, proto_err}, 32'd0);
      chk("cnt_cleared", {28'd0, ff_count}, 32'd0);
      adv();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
